pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
Parametrised, elastic pipeline-stage register for the ARM-subset core. It replaces fixed-width, always-load stage registers between ID/EXE, EXE/MEM and MEM/WB. It adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is fully registered, and a synchronous flush that turns held instructions into NOPs. It also carries a saturating stall counter for performance measurement.

Parameters:
DATA_W, 96, width of the datapath payload (PC, operands, immediates); not cleared on flush.
CTRL_W, 12, width of the control payload (WB_EN, MEM_R/W_EN, B, S, EXE_CMD...); cleared to 0 on flush and when drained.
CNT_W, 16, width of the stall counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous and active-high.
flush  in  1  synchronous flush (branch taken / exception).
in_valid  in  1  upstream holds a valid instruction.
in_ready  out  1  stage can accept; driven from a register only.
in_ctrl  in  CTRL_W  upstream control payload.
in_data  in  DATA_W  upstream data payload.
out_valid  out  1  main slot holds a valid instruction.
out_ready  in  1  downstream accepts (low = hazard stall).
out_ctrl  out  CTRL_W  main-slot control; 0 whenever out_valid=0.
out_data  out  DATA_W  main-slot data; don't-care when out_valid=0.
cnt_clr  in  1  synchronous clear of stall_cnt.
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage is a main slot (drives the outputs) plus a skid slot. State is EMPTY, ONE or FULL.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is decoded from the state register only and has no combinational path from out_ready.
- EMPTY: in_fire -> main<=in; go to ONE.
- ONE:
  - in_fire & out_fire -> main<=in; stay in ONE.
  - in_fire & !out_fire -> skid<=in; go to FULL.
  - !in_fire & out_fire -> main ctrl<=0; go to EMPTY.
  - Neither -> hold.
- FULL: out_fire -> main<=skid, skid ctrl<=0; go to ONE. Otherwise hold both slots.
- Latency is 1 cycle from in_fire to out_valid when the stage is EMPTY or draining. Throughput is 1 per cycle. Order is strictly FIFO, and no instruction is lost or duplicated.
- flush has the highest priority:
  - Next state is EMPTY.
  - Main and skid ctrl are cleared to 0; data registers hold.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as delivered: downstream has already consumed it.
- Reset (async, on rst high): state EMPTY; main and skid ctrl/data = 0; stall_cnt = 0. Outputs therefore read in_ready=1, out_valid=0, out_ctrl=0, out_data=0.
- Reset may be asserted mid-transfer. The stage empties immediately and the first accept happens on the first clk edge after rst falls.
- stall_cnt:
  - Increments by 1 when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment; cnt_clr and an increment in the same cycle give 0.
  - flush does not affect the counter.

Decomposition:
- A shared package pipe_pkg holds:
  - the state typedef pipe_state_t, encoded EMPTY=2'b00, ONE=2'b01, FULL=2'b10;
  - the localparam NOP_CTRL = '0.
- One sub-module, pipe_slot: a parametrised (CTRL_W, DATA_W) register with load, ctrl-clear and async reset. It is instantiated twice (main, skid).
- FSM and counter stay in the top module.

Test Plan:
1. Reset then stream: rst pulse; in_valid=1 with ctrl=0x0A1, 0x0A2, 0x0A3, out_ready=1 -> out_valid rises 1 cycle after the first in_fire; outputs 0x0A1/0x0A2/0x0A3 on consecutive cycles; in_ready stays 1.
2. Backpressure/skid: send 0x011 then 0x022; out_ready=0 for 3 cycles -> state FULL; in_ready=0 on the cycle after the second accept; stall_cnt=3; releasing out_ready delivers 0x011 then 0x022; in_ready returns to 1 after the first out_fire.
3. Flush while FULL: slots hold 0x033/0x044 and flush=1 with in_valid=1 and ctrl 0x055 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x055 is never emitted.
4. Flush coincident with out_fire in ONE: main holds 0x066, out_ready=1, flush=1 -> 0x066 counts delivered once; stage EMPTY afterwards.
5. Async reset mid-operation: rst asserted between clk edges while FULL -> out_valid=0 and stall_cnt=0 immediately, without waiting for a clk edge.
6. Counter saturation and clear: with CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15; pulse cnt_clr during the stall -> stall_cnt=0 the next cycle, then counts up from 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
// The state encoding is fixed so that existing logic-analyser decodes stay valid.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  // A control word of all zeros is an architectural NOP: no write-back, no memory access, no branch.
  localparam logic NOP_CTRL = '0;

endpackage

// File: rtl/pipe_slot.sv
// One ctrl/data holding register. Load and ctrl-clear are applied on the same clock edge, and clear wins.
// Latency is 1 cycle and there is no backpressure: the owner decides when the slot loads.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // Clearing touches only ctrl; the stale data is harmless once ctrl is a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clr) begin
      q_ctrl <= {CTRL_W{NOP_CTRL}};
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-NOP and a saturating stall counter.
// Latency is 1 cycle. in_ready is decoded purely from state, and the skid slot absorbs the one extra beat.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Main ctrl is cleared whenever the stage empties, so it can drive out_ctrl without gating.
  assign out_ctrl = main_ctrl;
  assign out_data = main_data;

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clr    (main_clr),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clr    (skid_clr),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  // Counts hazard stalls only; a flush must not disturb the measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
